write_back_stage: RTL
=====================

Name: write_back_stage

Overview:
- Final pipeline stage, directly downstream of the memory stage.
- Selects the register-file write-back value from the ALU result, the memory read/pop word, or the input port.
- Reassembles multi-word stack pops into a 32-bit PC redirect: RET pops 2 words; RTI pops 3 words and also restores flags.
- Holds upstream stages with a stall while a multi-word pop is in progress.

Parameters:
- DATA_WIDTH, 16, width of one memory word and of a register.
- PC_WIDTH, 32, program-counter width; must equal 2*DATA_WIDTH.
- FLAG_WIDTH, 3, flags width (low bits of the popped flags word).
- REG_ADDR_WIDTH, 3, register-file address width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- valid  in  1  instruction present from the MEM/WB buffer.
- flush  in  1  suppresses the instruction presented this cycle.
- wb_enable  in  1  instruction writes a register.
- wb_src_select  in  2  00 ALU, 01 memory, 10 in_port, 11 reserved (ALU).
- rdst  in  REG_ADDR_WIDTH  destination register.
- alu_result  in  DATA_WIDTH  ALU result.
- mem_data  in  DATA_WIDTH  word read or popped by the memory stage.
- mem_valid  in  1  mem_data is valid this cycle.
- in_port  in  DATA_WIDTH  input-port value.
- op_ret  in  1  RET instruction.
- op_rti  in  1  RTI instruction.
- reg_write_en  out  1  register-file write strobe.
- reg_write_addr  out  REG_ADDR_WIDTH  write address.
- reg_write_data  out  DATA_WIDTH  write data.
- pc_load  out  1  one-cycle PC redirect strobe.
- pc_target  out  PC_WIDTH  redirect address.
- flags_load  out  1  one-cycle flags restore strobe.
- flags_out  out  FLAG_WIDTH  restored flags.
- stall  out  1  upstream must hold; combinational from state.

Behaviour:
- Reset: all outputs 0; state IDLE; PC assembly register cleared.
- Stack convention: pushes go flags, then PC high, then PC low. Pops therefore arrive PC low, PC high, flags.
- All outputs except stall are registered. Latency is 1 cycle from the qualifying input edge.
- Accept condition in IDLE: valid & !flush.
- IDLE, plain instruction (op_ret=0, op_rti=0): next cycle reg_write_en = wb_enable, reg_write_addr = rdst, reg_write_data per wb_src_select.
- IDLE, op_ret or op_rti: never writes a register.
  - If mem_valid is high: capture mem_data as PC low word and go to HI.
  - If mem_valid is low: go to WAIT_LO.
  - Set mode to RTI if op_rti, otherwise RET. op_rti has priority when both are set.
- WAIT_LO: on mem_valid, capture the low word and go to HI. Otherwise stay.
- HI: on mem_valid, form {mem_data, low} as the target. Otherwise stay.
  - RET mode: pc_target = {mem_data, low}; pc_load = 1 next cycle; go to IDLE.
  - RTI mode: hold the target; go to FLAGS.
- FLAGS (RTI only): on mem_valid, next cycle pc_load = 1, flags_load = 1, pc_target = held value, flags_out = mem_data[FLAG_WIDTH-1:0]; go to IDLE. Otherwise stay.
- stall: high in WAIT_LO, HI, and FLAGS. Also high combinationally in IDLE when an accepted instruction has op_ret or op_rti set.
- While stall is high, valid, wb_* and rdst are ignored; upstream holds them.
- flush: effective only in IDLE. Ignored in the other states because a committed pop sequence completes.
- pc_load and flags_load are single-cycle pulses. pc_target and flags_out hold their value until the next load.
- reg_write_en is a single-cycle pulse per accepted instruction. reg_write_addr and reg_write_data hold their value.
- Reset mid-sequence: returns to IDLE next edge, clears the partial word, issues no pc_load.
- Back-to-back: a new instruction may be accepted in IDLE in the same cycle pc_load is asserted from the previous sequence.

Test Plan:
- Reset, then valid=1, wb_enable=1, wb_src_select=00, rdst=5, alu_result=16'h1234 -> next cycle reg_write_en=1, reg_write_addr=5, reg_write_data=16'h1234; the cycle after that reg_write_en=0.
- Source select sweep: src 01 with mem_data=16'hBEEF, then src 10 with in_port=16'h00AA -> write data 16'hBEEF, then 16'h00AA. Then valid=1, flush=1 -> no write.
- RET with mem_valid every cycle, words 16'hABCD then 16'hDCBA -> stall high for 2 cycles; pc_load pulses once with pc_target=32'hDCBAABCD; reg_write_en stays 0.
- RTI with words 16'hABCD, 16'hDCBA, 16'h0007 -> stall for 3 cycles; pc_load=1 and flags_load=1 in the same cycle; pc_target=32'hDCBAABCD; flags_out=3'b111.
- RET with mem_valid low for 2 cycles between the words -> stall extends 2 cycles and the result is unchanged. Separately, op_ret and op_rti both set -> RTI behaviour.
- Reset asserted while in HI after the low word -> state IDLE, no pc_load, all outputs 0. A following RET completes normally.

Source files
------------

// File: rtl/write_back_stage.sv
// write_back_stage
//   Final pipeline stage, fed by the MEM/WB buffer. Picks the register-file
//   write-back value (ALU result, memory word or input port) and reassembles
//   multi-word stack pops into a PC redirect:
//     RET pops PC low, PC high.
//     RTI pops PC low, PC high, flags.
//   Upstream is held with stall while a pop sequence is in flight.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   valid, flush        instruction present / suppress it (flush only acts in IDLE)
//   wb_enable           instruction writes a register
//   wb_src_select       00 ALU, 01 memory, 10 in_port, 11 ALU
//   rdst                destination register
//   alu_result          ALU result
//   mem_data, mem_valid word read or popped by the memory stage, and its qualifier
//   in_port             input-port value
//   op_ret, op_rti      return instructions (op_rti wins if both are set)
//   reg_write_*         registered register-file write port (en is a 1-cycle pulse)
//   pc_load, pc_target  registered PC redirect (load is a 1-cycle pulse, target holds)
//   flags_load, flags_out registered flags restore (load is a 1-cycle pulse, flags hold)
//   stall               combinational upstream hold
//
// PC_WIDTH must equal 2*DATA_WIDTH: the target is built from two popped words.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | accepting instructions; a pop instruction starts a sequence
// WAIT_LO | pop accepted, waiting for the PC low word
// HI      | low word held, waiting for the PC high word
// FLAGS   | RTI only: full target held, waiting for the flags word

module write_back_stage #(
  parameter int DATA_WIDTH     = 16,
  parameter int PC_WIDTH       = 32,
  parameter int FLAG_WIDTH     = 3,
  parameter int REG_ADDR_WIDTH = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      valid,
  input  logic                      flush,
  input  logic                      wb_enable,
  input  logic [1:0]                wb_src_select,
  input  logic [REG_ADDR_WIDTH-1:0] rdst,
  input  logic [DATA_WIDTH-1:0]     alu_result,
  input  logic [DATA_WIDTH-1:0]     mem_data,
  input  logic                      mem_valid,
  input  logic [DATA_WIDTH-1:0]     in_port,
  input  logic                      op_ret,
  input  logic                      op_rti,
  output logic                      reg_write_en,
  output logic [REG_ADDR_WIDTH-1:0] reg_write_addr,
  output logic [DATA_WIDTH-1:0]     reg_write_data,
  output logic                      pc_load,
  output logic [PC_WIDTH-1:0]       pc_target,
  output logic                      flags_load,
  output logic [FLAG_WIDTH-1:0]     flags_out,
  output logic                      stall
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_LO = 2'd1,
    HI      = 2'd2,
    FLAGS   = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic                      mode_rti, mode_rti_nxt;
  logic [DATA_WIDTH-1:0]     lo_word, lo_word_nxt;
  logic [DATA_WIDTH-1:0]     hi_word, hi_word_nxt;

  logic                      reg_write_en_nxt;
  logic [REG_ADDR_WIDTH-1:0] reg_write_addr_nxt;
  logic [DATA_WIDTH-1:0]     reg_write_data_nxt;
  logic                      pc_load_nxt;
  logic [PC_WIDTH-1:0]       pc_target_nxt;
  logic                      flags_load_nxt;
  logic [FLAG_WIDTH-1:0]     flags_out_nxt;

  logic                      accept;
  logic                      is_pop;
  logic [DATA_WIDTH-1:0]     wb_value;

  assign accept = valid & ~flush;
  assign is_pop = op_ret | op_rti;

  // Stall must rise in the same cycle the pop is accepted, before the
  // state register has moved, so the IDLE term is combinational.
  assign stall = (state != IDLE) | (accept & is_pop);

  always_comb begin
    case (wb_src_select)
      2'b01:   wb_value = mem_data;
      2'b10:   wb_value = in_port;
      default: wb_value = alu_result;
    endcase
  end

  always_comb begin
    state_nxt          = state;
    mode_rti_nxt       = mode_rti;
    lo_word_nxt        = lo_word;
    hi_word_nxt        = hi_word;
    reg_write_en_nxt   = 1'b0;
    reg_write_addr_nxt = reg_write_addr;
    reg_write_data_nxt = reg_write_data;
    pc_load_nxt        = 1'b0;
    pc_target_nxt      = pc_target;
    flags_load_nxt     = 1'b0;
    flags_out_nxt      = flags_out;

    case (state)
      IDLE: begin
        if (accept) begin
          if (is_pop) begin
            mode_rti_nxt = op_rti;
            if (mem_valid) begin
              lo_word_nxt = mem_data;
              state_nxt   = HI;
            end else begin
              state_nxt = WAIT_LO;
            end
          end else begin
            reg_write_en_nxt   = wb_enable;
            reg_write_addr_nxt = rdst;
            reg_write_data_nxt = wb_value;
          end
        end
      end
      WAIT_LO: begin
        if (mem_valid) begin
          lo_word_nxt = mem_data;
          state_nxt   = HI;
        end
      end
      HI: begin
        if (mem_valid) begin
          if (mode_rti) begin
            hi_word_nxt = mem_data;
            state_nxt   = FLAGS;
          end else begin
            pc_target_nxt = {mem_data, lo_word};
            pc_load_nxt   = 1'b1;
            state_nxt     = IDLE;
          end
        end
      end
      FLAGS: begin
        if (mem_valid) begin
          pc_target_nxt  = {hi_word, lo_word};
          flags_out_nxt  = mem_data[FLAG_WIDTH-1:0];
          pc_load_nxt    = 1'b1;
          flags_load_nxt = 1'b1;
          state_nxt      = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      mode_rti       <= 1'b0;
      lo_word        <= '0;
      hi_word        <= '0;
      reg_write_en   <= 1'b0;
      reg_write_addr <= '0;
      reg_write_data <= '0;
      pc_load        <= 1'b0;
      pc_target      <= '0;
      flags_load     <= 1'b0;
      flags_out      <= '0;
    end else begin
      state          <= state_nxt;
      mode_rti       <= mode_rti_nxt;
      lo_word        <= lo_word_nxt;
      hi_word        <= hi_word_nxt;
      reg_write_en   <= reg_write_en_nxt;
      reg_write_addr <= reg_write_addr_nxt;
      reg_write_data <= reg_write_data_nxt;
      pc_load        <= pc_load_nxt;
      pc_target      <= pc_target_nxt;
      flags_load     <= flags_load_nxt;
      flags_out      <= flags_out_nxt;
    end
  end

endmodule
